// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with pointer register, auto-increment and host-side register file
module i2c_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1,
  localparam int PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       slave_addr,
  input  logic             scl,
  inout  wire              sda,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_waddr,
  input  logic [7:0]       host_wdata,
  input  logic [PTR_W-1:0] host_raddr,
  output logic [7:0]       host_rdata,
  output logic             addr_match,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  output logic             rd_strobe,
  output logic             busy,
  output logic [3:0]       debug_state,
  output logic             debug_sda_oe
);

  // Storage is rounded up to a power of two so every host index is in range.
  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]             shreg;
  logic [3:0]             bit_cnt;
  logic [PTR_W-1:0]       ptr, ptr_inc;
  logic [6:0]             addr_q;
  logic [7:0]             regs [DEPTH];
  logic [7:0]             rx_next, rd_byte;
  logic                   sda_oe, oe_next;
  logic                   act_shift_in, act_wr, act_ptr_load, act_rd_load, act_shift_out;
  logic                   cnt_clr, match_pulse, ptr_ok, counting;

  assign sda          = sda_oe ? 1'b0 : 1'bz;
  assign scl_s        = scl_sync[SYNC_STAGES-1];
  assign sda_s        = sda_sync[SYNC_STAGES-1];
  assign scl_rise     = scl_s & ~scl_d;
  assign scl_fall     = ~scl_s & scl_d;
  assign start_det    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det     = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_next      = {shreg[6:0], sda_s};
  assign rd_byte      = regs[ptr];
  assign ptr_inc      = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_ok       = 32'(shreg) < NUM_REGS;
  assign counting     = (state == ADDR) || (state == PTR) || (state == WDATA) || (state == RDATA);
  assign host_rdata   = regs[host_raddr];
  assign debug_state  = state;
  assign debug_sda_oe = sda_oe;

  // Bus synchroniser plus one extra flop per line for edge detection; idles high like the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, next SDA drive and datapath actions; STOP/START override every state.
  always_comb begin
    state_next    = state;
    oe_next       = sda_oe;
    act_wr        = 1'b0;
    act_ptr_load  = 1'b0;
    act_rd_load   = 1'b0;
    act_shift_out = 1'b0;
    cnt_clr       = 1'b0;
    match_pulse   = 1'b0;
    act_shift_in  = scl_rise && (bit_cnt < 4'd8) &&
                    ((state == ADDR) || (state == PTR) || (state == WDATA));
    if (stop_det) begin
      state_next = IDLE;
      oe_next    = 1'b0;
    end else if (start_det) begin
      state_next = ADDR;
      oe_next    = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == addr_q) begin
              state_next  = ADDR_ACK;
              oe_next     = 1'b1;
              match_pulse = 1'b1;
            end else begin
              state_next = WAIT_STOP;
              oe_next    = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_clr = 1'b1;
            if (shreg[0]) begin
              state_next  = RDATA;
              act_rd_load = 1'b1;
              oe_next     = ~rd_byte[7];
            end else begin
              state_next = PTR;
              oe_next    = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            if (ptr_ok) begin
              state_next   = PTR_ACK;
              act_ptr_load = 1'b1;
              oe_next      = 1'b1;
            end else begin
              state_next = WAIT_STOP;
              oe_next    = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_next = WDATA;
            oe_next    = 1'b0;
            cnt_clr    = 1'b1;
          end
        end
        WDATA: begin
          // The byte is committed on its 8th rising edge; ACK follows on the next fall.
          if (scl_rise && bit_cnt == 4'd7) act_wr = 1'b1;
          if (scl_fall && bit_cnt == 4'd8) begin
            state_next = WDATA_ACK;
            oe_next    = 1'b1;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_next = RDATA_ACK;
              oe_next    = 1'b0;
            end else begin
              act_shift_out = 1'b1;
              oe_next       = ~shreg[6];
            end
          end
        end
        RDATA_ACK: begin
          // NACK leaves on the sampling edge; a later fall therefore always means ACK.
          if (scl_rise && sda_s) begin
            state_next = WAIT_STOP;
          end else if (scl_fall) begin
            state_next  = RDATA;
            act_rd_load = 1'b1;
            cnt_clr     = 1'b1;
            oe_next     = ~rd_byte[7];
          end
        end
        default: oe_next = 1'b0;
      endcase
    end
  end

  // Shift register, bit counter, pointer, SDA drive and host-visible strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      addr_q     <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_ptr     <= '0;
      wr_data    <= '0;
      rd_strobe  <= 1'b0;
    end else begin
      sda_oe     <= oe_next;
      addr_match <= match_pulse;
      wr_strobe  <= act_wr;
      rd_strobe  <= act_rd_load;
      if (start_det) begin
        busy   <= 1'b1;
        addr_q <= slave_addr;
      end else if (stop_det) begin
        busy <= 1'b0;
      end
      if (cnt_clr)                               bit_cnt <= '0;
      else if (scl_rise && counting && bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
      if (act_rd_load)        shreg <= rd_byte;
      else if (act_shift_out) shreg <= {shreg[6:0], 1'b0};
      else if (act_shift_in)  shreg <= rx_next;
      if (act_ptr_load)                                ptr <= shreg[PTR_W-1:0];
      else if ((act_wr || act_rd_load) && AUTO_INC != 0) ptr <= ptr_inc;
      if (act_wr) begin
        wr_ptr  <= ptr;
        wr_data <= rx_next;
      end
    end
  end

  // Register bank; the I2C write is issued last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (host_we) regs[host_waddr] <= host_wdata;
      if (act_wr)  regs[ptr]        <= rx_next;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - scoreboard bench for i2c_slave_regfile (auto-inc and hold-pointer targets on one bus)
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;

  logic       hwe0 = 1'b0, hwe1 = 1'b0;
  logic [3:0] hwaddr0 = '0, hwaddr1 = '0, hraddr0 = '0, hraddr1 = '0;
  logic [7:0] hwdata0 = '0, hwdata1 = '0;
  logic [7:0] hrdata0, hrdata1, wdat0, wdat1;
  logic [3:0] wptr0, wptr1, dstate0, dstate1;
  logic       match0, match1, wstb0, wstb1, rstb0, rstb1, busy0, busy1, oe0, oe1;

  int         total = 0;
  int         bad = 0;
  int         n_match0 = 0, n_match1 = 0, n_rd0 = 0, n_oe = 0;
  logic [12:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.NUM_REGS(16), .SYNC_STAGES(2), .AUTO_INC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .slave_addr(7'h55), .scl(scl), .sda(sda),
    .host_we(hwe0), .host_waddr(hwaddr0), .host_wdata(hwdata0),
    .host_raddr(hraddr0), .host_rdata(hrdata0), .addr_match(match0),
    .wr_strobe(wstb0), .wr_ptr(wptr0), .wr_data(wdat0), .rd_strobe(rstb0),
    .busy(busy0), .debug_state(dstate0), .debug_sda_oe(oe0)
  );

  i2c_slave_regfile #(.NUM_REGS(16), .SYNC_STAGES(2), .AUTO_INC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .slave_addr(7'h56), .scl(scl), .sda(sda),
    .host_we(hwe1), .host_waddr(hwaddr1), .host_wdata(hwdata1),
    .host_raddr(hraddr1), .host_rdata(hrdata1), .addr_match(match1),
    .wr_strobe(wstb1), .wr_ptr(wptr1), .wr_data(wdat1), .rd_strobe(rstb1),
    .busy(busy1), .debug_state(dstate1), .debug_sda_oe(oe1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write strobes are popped against the scoreboard; other events are just counted.
  always @(negedge clk) begin
    if (wstb0) begin
      if (exp_wr.size() == 0) check("wr0_extra", 32'(exp_wr.size()), 32'd1);
      else check("wr0", 32'({1'b0, wptr0, wdat0}), 32'(exp_wr.pop_front()));
    end
    if (wstb1) begin
      if (exp_wr.size() == 0) check("wr1_extra", 32'(exp_wr.size()), 32'd1);
      else check("wr1", 32'({1'b1, wptr1, wdat1}), 32'(exp_wr.pop_front()));
    end
    if (match0)      n_match0 <= n_match0 + 1;
    if (match1)      n_match1 <= n_match1 + 1;
    if (rstb0)       n_rd0    <= n_rd0 + 1;
    if (oe0 || oe1)  n_oe     <= n_oe + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bit_cycle(input logic b, output logic s);
    m_low = ~b;
    #50 scl = 1'b1;
    #50 s = sda;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic i2c_start();
    m_low = 1'b1;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0;
    #50 scl = 1'b1;
    #50 m_low = 1'b1;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #50 scl = 1'b1;
    #50 m_low = 1'b0;
    #100;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_check(input string tag, input logic nack);
    logic [7:0] d;
    logic       s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
    if (exp_rd.size() == 0) check(tag, 32'(exp_rd.size()), 32'd1);
    else check(tag, 32'(d), 32'(exp_rd.pop_front()));
  endtask

  task automatic host_write0(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    hwe0 = 1'b1; hwaddr0 = a; hwdata0 = d;
    @(negedge clk);
    hwe0 = 1'b0;
  endtask

  initial begin
    logic ack, s;
    int   m0, m1, rd_base, oe_base;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sda", 32'(sda), 1);
    check("rst_oe", 32'(oe0), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    hraddr0 = 4'd3;
    #1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_state", 32'(dstate0), 0);
    check("rst_strobes", 32'({match0, wstb0, rstb0}), 0);
    check("rst_reg", 32'(hrdata0), 0);

    // Pointer 3, two data bytes, auto-increment to 4.
    exp_wr.push_back({1'b0, 4'd3, 8'hA5});
    exp_wr.push_back({1'b0, 4'd4, 8'h5A});
    i2c_start();
    send_byte(8'hAA, ack); check("t1_addr_ack", 32'(ack), 0);
    check("t1_busy", 32'(busy0), 1);
    send_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 0);
    send_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 0);
    send_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 0);
    i2c_stop();
    check("t1_busy_drop", 32'(busy0), 0);
    check("t1_match_cnt", 32'(n_match0), 1);
    check("t1_wr_drain", 32'(exp_wr.size()), 0);
    hraddr0 = 4'd3; #1 check("t1_reg3", 32'(hrdata0), 32'hA5);
    hraddr0 = 4'd4; #1 check("t1_reg4", 32'(hrdata0), 32'h5A);

    // Host preload, pointer 15, repeated START read of two bytes across the wrap.
    host_write0(4'd15, 8'h3C);
    host_write0(4'd0, 8'hC3);
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hC3);
    rd_base = n_rd0;
    i2c_start();
    send_byte(8'hAA, ack);
    send_byte(8'h0F, ack); check("t2_ptr_ack", 32'(ack), 0);
    i2c_rstart();
    send_byte(8'hAB, ack); check("t2_raddr_ack", 32'(ack), 0);
    recv_check("t2_rd0", 1'b0);
    recv_check("t2_rd1", 1'b1);
    check("t2_wait_stop", 32'(dstate0), 9);
    check("t2_rd_strobes", 32'(n_rd0 - rd_base), 2);
    i2c_stop();

    // Foreign address: nobody answers.
    oe_base = n_oe; m0 = n_match0; m1 = n_match1;
    i2c_start();
    send_byte(8'h66, ack); check("t3_ack_error", 32'(ack), 1);
    i2c_stop();
    check("t3_no_pulldown", 32'(n_oe - oe_base), 0);
    check("t3_no_match", 32'(n_match0 + n_match1 - m0 - m1), 0);

    // Out-of-range pointer is NACKed and the old pointer (1) survives.
    host_write0(4'd1, 8'h9E);
    i2c_start();
    send_byte(8'hAA, ack); check("t4_addr_ack", 32'(ack), 0);
    send_byte(8'h10, ack); check("t4_ptr_nack", 32'(ack), 1);
    send_byte(8'h77, ack); check("t4_data_nack", 32'(ack), 1);
    i2c_stop();
    exp_rd.push_back(8'h9E);
    i2c_start();
    send_byte(8'hAB, ack);
    recv_check("t4_ptr_kept", 1'b1);
    i2c_stop();

    // Hold-pointer target: both bytes land in register 2.
    exp_wr.push_back({1'b1, 4'd2, 8'h11});
    exp_wr.push_back({1'b1, 4'd2, 8'h22});
    i2c_start();
    send_byte(8'hAC, ack); check("t5_addr_ack", 32'(ack), 0);
    send_byte(8'h02, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack); check("t5_d1_ack", 32'(ack), 0);
    i2c_stop();
    check("t5_wr_drain", 32'(exp_wr.size()), 0);
    hraddr1 = 4'd2; #1 check("t5_reg2", 32'(hrdata1), 32'h22);
    hraddr1 = 4'd3; #1 check("t5_reg3", 32'(hrdata1), 32'h00);

    // Reset during the 4th bit of a read of 0xA5 (that bit is 0, so SDA is held low).
    i2c_start();
    send_byte(8'hAA, ack);
    send_byte(8'h03, ack);
    i2c_rstart();
    send_byte(8'hAB, ack);
    bit_cycle(1'b1, s); check("t6_b7", 32'(s), 1);
    bit_cycle(1'b1, s); check("t6_b6", 32'(s), 0);
    bit_cycle(1'b1, s); check("t6_b5", 32'(s), 1);
    #10;
    check("t6_driving", 32'(oe0), 1);
    rst_n = 1'b0;
    #1;
    check("t6_sda_rel", 32'(sda), 1);
    check("t6_oe_rel", 32'(oe0), 0);
    check("t6_busy", 32'(busy0), 0);
    check("t6_state", 32'(dstate0), 0);
    #30 rst_n = 1'b1;
    m_low = 1'b0;
    #50 scl = 1'b1;
    #200;
    for (int i = 0; i < 16; i++) begin
      hraddr0 = 4'(i);
      #1 check("t6_cleared", 32'(hrdata0), 0);
    end
    hraddr1 = 4'd2; #1 check("t6_cleared_u1", 32'(hrdata1), 0);
    check("end_rd_drain", 32'(exp_rd.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C target with an internal register file, pointer register and auto-increment, replacing the single-byte `i2c_slave` wherever an addressable register bank is needed on the bus. It sits on the same open-drain `sda`/`scl` bus as `i2c_master`. The first written byte selects a register pointer; subsequent writes and reads stream through the bank, with repeated START supported. The host side gets a parallel read/write port plus per-byte strobes.

## Interface
- `NUM_REGS`, 16: number of 8-bit registers, 2..256; `PTR_W = $clog2(NUM_REGS)` is derived.
- `SYNC_STAGES`, 2: input synchroniser depth on `scl` and `sda`, 2..3.
- `AUTO_INC`, 1: 1 = pointer increments after every data byte; 0 = pointer holds.
- `clk`  in  1  system clock; must be ≥16× the SCL frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `slave_addr`  in  7  bus address; sampled at each START.
- `scl`  in  1  bus clock; input only, no clock stretching.
- `sda`  inout  1  open-drain; driven `0` when `debug_sda_oe=1`, else `'z`.
- `host_we`  in  1  host write enable.
- `host_waddr`  in  PTR_W  host write index.
- `host_wdata`  in  8  host write data.
- `host_raddr`  in  PTR_W  host read index.
- `host_rdata`  out  8  `regs[host_raddr]`; combinational.
- `addr_match`  out  1  1-clk pulse when the address byte matches and ACK is driven.
- `wr_strobe`  out  1  1-clk pulse when an I2C data byte is written to the bank.
- `wr_ptr`  out  PTR_W  index written; valid with `wr_strobe`.
- `wr_data`  out  8  byte written; valid with `wr_strobe`.
- `rd_strobe`  out  1  1-clk pulse when a byte is loaded for transmission.
- `busy`  out  1  high from START until STOP.
- `debug_state`  out  4  FSM state encoding.
- `debug_sda_oe`  out  1  internal SDA pull-down enable.

## Operation
- Reset: all outputs 0, `sda` released, pointer 0, all registers 0, FSM in IDLE.
- Synchroniser: `scl` and `sda` each pass through `SYNC_STAGES` flops, followed by one edge-detect flop.
- START: synchronised SDA falls while SCL is high, in any state → ADDR, bit counter cleared, `busy`=1.
- STOP: SDA rises while SCL is high, in any state → IDLE, SDA released, `busy`=0.
- Bits are shifted in MSB first on SCL rising edges. SDA is changed only after an SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR, after 8 bits:
  - `addr[7:1]≠slave_addr` → WAIT_STOP, no ACK.
  - Match with R/W=0 → ADDR_ACK, then PTR.
  - Match with R/W=1 → ADDR_ACK, then RDATA.
- PTR: received byte < `NUM_REGS` → pointer loaded, ACK, then WDATA. Byte ≥ `NUM_REGS` → NACK (SDA released), pointer unchanged, WAIT_STOP.
- WDATA, after 8 bits:
  - `regs[ptr]` ← byte; `wr_strobe`/`wr_ptr`/`wr_data` fire; ACK.
  - If `AUTO_INC`: pointer ← (ptr+1) mod `NUM_REGS`.
  - Loops in WDATA until STOP or START.
- RDATA:
  - Shift register loads `regs[ptr]` on entry, `rd_strobe` pulses.
  - Pointer auto-increments (same wrap rule).
  - 8 bits are driven, then RDATA_ACK samples the controller's bit on the 9th SCL rising edge.
  - ACK (0) → RDATA. NACK (1) → WAIT_STOP.
- WAIT_STOP: SDA released; exits only on START or STOP.
- The pointer is retained across transactions, so write-pointer then Sr+read is supported.
- Simultaneous host write and I2C write to the same index: the I2C write wins. Different indices: both complete in the same clk.

## Timing
- Pin-to-detect latency: `SYNC_STAGES`+1 clk.
- ACK drive: `debug_sda_oe`=1 within 1 clk of the 8th SCL falling-edge detect; released within 1 clk of the 9th falling-edge detect.
- Read data: the first bit is driven within 1 clk of the ACK-phase falling-edge detect. Each subsequent bit changes within 1 clk of its falling-edge detect.
- `wr_strobe` is asserted in the clk after the 8th rising-edge detect of a WDATA byte.
- `addr_match` is asserted in the same clk that ADDR_ACK is entered.
- `rst_n` low mid-transfer: SDA is released asynchronously and the FSM returns to IDLE. Register contents are also cleared.

## Test plan
- Write 0x55/W, ptr 0x03, data 0xA5, 0x5A, STOP → both ACKed; `regs[3]`=0xA5, `regs[4]`=0x5A; two `wr_strobe` pulses with `wr_ptr` 3 then 4; `busy` drops after STOP.
- Host writes `regs[15]`=0x3C and `regs[0]`=0xC3. Then 0x55/W with ptr 0x0F, followed by Sr, 0x55/R, 2 bytes (ACK then NACK) → master reads 0x3C then 0xC3 (pointer wraps); `rd_strobe` pulses twice; FSM ends in WAIT_STOP.
- Address 0x33 → SDA never pulled low, no strobes, `addr_match`=0, master `ack_error`=1.
- `NUM_REGS`=16, ptr byte 0x10 → NACK on the pointer byte, no `wr_strobe`, pointer keeps its old value.
- `AUTO_INC`=0: ptr 0x02, data 0x11, 0x22 → `regs[2]`=0x22 and `regs[3]` unchanged.
- `rst_n` pulsed low during the 4th read bit → `sda` released in the same cycle, `busy`=0, `host_rdata` of every register reads 0x00.
